// File: rtl/prga_fifo_unit.sv
// Single-clock FIFO with a selectable read interface (registered or first-word-fall-through).
// An optional conversion stage builds the storage core in the opposite mode and adapts it.

module prga_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 1,
  parameter int LA         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rd,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wptr;
  logic [DEPTH_LOG2:0]   r_rptr;
  logic [DEPTH_LOG2-1:0] w_waddr;
  logic [DEPTH_LOG2-1:0] w_raddr;
  logic                  w_push;
  logic                  w_pop;

  assign w_waddr = r_wptr[DEPTH_LOG2-1:0];
  assign w_raddr = r_rptr[DEPTH_LOG2-1:0];
  // The extra pointer MSB distinguishes a full ring from an empty one.
  assign empty   = (r_wptr == r_rptr);
  assign full    = (w_waddr == w_raddr) && (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]);
  assign w_push  = wr && !full;
  assign w_pop   = rd && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_waddr] <= din;
  end

  generate
    if (LA != 0) begin : g_la
      assign dout = r_mem[w_raddr];
    end else begin : g_nla
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_dout <= '0;
        else if (w_pop) r_dout <= r_mem[w_raddr];
      end
      assign dout = r_dout;
    end
  endgenerate
endmodule

module prga_fifo_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 1,
  parameter int LOOKAHEAD  = 0,
  parameter int CONVERT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);
  generate
    if (CONVERT == 0) begin : g_direct
      prga_fifo_core #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .LA(LOOKAHEAD)
      ) u_core (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full),
        .rd(rd), .empty(empty), .dout(dout)
      );
    end else if (LOOKAHEAD != 0) begin : g_nla2la
      logic                  w_core_empty;
      logic [DATA_WIDTH-1:0] w_cdout;
      logic                  w_rd_i;
      logic                  w_pop;
      logic [2:0]            w_occ;
      logic [DATA_WIDTH-1:0] r_buf0;
      logic [DATA_WIDTH-1:0] r_buf1;
      logic [1:0]            r_cnt;
      logic                  r_pend;

      prga_fifo_core #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .LA(0)
      ) u_core (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full),
        .rd(w_rd_i), .empty(w_core_empty), .dout(w_cdout)
      );

      assign empty  = (r_cnt == 2'd0);
      assign dout   = r_buf0;
      assign w_pop  = rd && !empty;
      // Count words that will still occupy the buffer after this edge, including the one
      // arriving from an in-flight core read; pop only implies r_cnt>=1, so no underflow.
      assign w_occ  = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
      assign w_rd_i = !w_core_empty && (w_occ < 3'd2);

      // Stage boundary: core read issued now, its data lands in the buffer next cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_buf0 <= '0;
          r_buf1 <= '0;
          r_cnt  <= 2'd0;
          r_pend <= 1'b0;
        end else begin
          r_pend <= w_rd_i;
          case ({w_pop, r_pend})
            2'b11: begin
              if (r_cnt == 2'd2) begin
                r_buf0 <= r_buf1;
                r_buf1 <= w_cdout;
              end else begin
                r_buf0 <= w_cdout;
              end
            end
            2'b10: begin
              r_buf0 <= r_buf1;
              r_cnt  <= r_cnt - 2'd1;
            end
            2'b01: begin
              if (r_cnt == 2'd0) r_buf0 <= w_cdout;
              else               r_buf1 <= w_cdout;
              r_cnt <= r_cnt + 2'd1;
            end
            default: ;
          endcase
        end
      end
    end else begin : g_la2nla
      logic                  w_core_empty;
      logic [DATA_WIDTH-1:0] w_chead;
      logic                  w_rd_i;
      logic [DATA_WIDTH-1:0] r_dout;

      prga_fifo_core #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .LA(1)
      ) u_core (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full),
        .rd(w_rd_i), .empty(w_core_empty), .dout(w_chead)
      );

      assign w_rd_i = rd && !w_core_empty;
      assign empty  = w_core_empty;
      assign dout   = r_dout;

      // Stage boundary: fall-through head registered on each accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_dout <= '0;
        else if (w_rd_i) r_dout <= w_chead;
      end
    end
  endgenerate
endmodule

// File: tb/tb_prga_fifo_unit.sv
// Drives all four interface/conversion configurations with shared stimulus and checks
// each against a queue-level reference model.

module tb_prga_fifo_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full  [4];
  logic       empty [4];
  logic [7:0] dout  [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Exact models for instances 0..2 (capacity 2); scoreboard for instance 3.
  logic [7:0] mq [3][4];
  int         mn [3];
  logic [7:0] mdout [3];
  logic [7:0] sb3 [$];
  int         stall3;

  always #5 clk = ~clk;

  prga_fifo_unit #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(0), .CONVERT(0)) u0 (
    .clk(clk), .rst(rst), .full(full[0]), .wr(wr), .din(din),
    .empty(empty[0]), .rd(rd), .dout(dout[0]));
  prga_fifo_unit #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(1), .CONVERT(0)) u1 (
    .clk(clk), .rst(rst), .full(full[1]), .wr(wr), .din(din),
    .empty(empty[1]), .rd(rd), .dout(dout[1]));
  prga_fifo_unit #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(0), .CONVERT(1)) u2 (
    .clk(clk), .rst(rst), .full(full[2]), .wr(wr), .din(din),
    .empty(empty[2]), .rd(rd), .dout(dout[2]));
  prga_fifo_unit #(.DATA_WIDTH(8), .DEPTH_LOG2(1), .LOOKAHEAD(1), .CONVERT(1)) u3 (
    .clk(clk), .rst(rst), .full(full[3]), .wr(wr), .din(din),
    .empty(empty[3]), .rd(rd), .dout(dout[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 3; i++) begin
      mn[i]    = 0;
      mdout[i] = 8'h00;
    end
    sb3.delete();
    stall3 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_full%0d", i), full[i], 0);
      chk($sformatf("rst_empty%0d", i), empty[i], 1);
      if (i != 1) chk($sformatf("rst_dout%0d", i), dout[i], 0);
    end
    clear_models();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit pop3;
    bit push3;
    bit pop;
    bit push;
    @(negedge clk);
    wr  = w;
    rd  = r;
    din = d;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full%0d", i), full[i], mn[i] == 2);
      chk($sformatf("empty%0d", i), empty[i], mn[i] == 0);
      if (i == 1) begin
        if (mn[1] != 0) chk("dout1", dout[1], mq[1][0]);
      end else begin
        chk($sformatf("dout%0d", i), dout[i], mdout[i]);
      end
    end
    if (!empty[3]) begin
      if (sb3.size() == 0) chk("dout3_spurious", 1, 0);
      else                 chk("dout3", dout[3], sb3[0]);
    end
    chk("full3_bound", full[3] && (sb3.size() < 2), 0);
    chk("cap3", sb3.size() > 4, 0);
    if (sb3.size() != 0 && empty[3]) stall3++;
    else                             stall3 = 0;
    chk("stall3", stall3 > 3, 0);
    pop3  = r && !empty[3];
    push3 = w && !full[3];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pop  = r && (mn[i] != 0);
      push = w && (mn[i] != 2);
      if (pop) begin
        mdout[i] = mq[i][0];
        for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
        mn[i]--;
      end
      if (push) begin
        mq[i][mn[i]] = d;
        mn[i]++;
      end
    end
    if (pop3)  void'(sb3.pop_front());
    if (push3) sb3.push_back(d);
  endtask

  logic [7:0] seq [8];
  int         pw;
  int         pr;

  initial begin
    seq = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
    clear_models();

    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, seq[k]);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);

    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, seq[k]);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) chk($sformatf("s2_empty%0d", i), empty[i], 1);

    do_reset();
    for (int k = 0; k < 40; k++) step(k < 8, 1'($urandom_range(0, 1)), seq[k % 8]);

    do_reset();
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h44);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00);

    do_reset();
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b0, 1'b0, 8'h00);
    do_reset();
    step(1'b1, 1'b0, 8'h5A);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h00);

    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 50 : 95;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
      end
    end

    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) chk($sformatf("drain_model%0d", i), 32'(mn[i]), 0);
    chk("drain_sb3", sb3.size(), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_empty%0d", i), empty[i], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
